// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared constants, alarm state type and helpers for the mode controller
package watch_pkg;

   localparam int N_MODES = 7;
   localparam int DISP_W  = 48;
   localparam int N_BTNS  = 6;

   localparam int DATE      = 0;
   localparam int CLOCK     = 1;
   localparam int ALARM_SET = 2;
   localparam int STOPWATCH = 3;
   localparam int TIMER     = 4;
   localparam int WORLD     = 5;
   localparam int LADDER    = 6;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_ENTER = 4;
   localparam int BTN_ESC   = 5;

   typedef enum logic {
      IDLE = 1'b0,
      RING = 1'b1
   } alarm_state_t;

   function automatic logic [N_MODES-1:0] idx_onehot(input logic [2:0] idx);
      return N_MODES'(1) << idx;
   endfunction

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [2:0] lowest_set(input logic [N_MODES-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = N_MODES - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic logic is_onehot(input logic [N_MODES-1:0] v);
      return (v != '0) && ((v & (v - N_MODES'(1))) == '0);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debouncer and press-edge pulse for one active-low button
module btn_debounce #(
   parameter int DB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);

   logic        sync_q1;
   logic        sync_q2;
   logic        pressed_s;
   logic        level;
   logic        level_d;
   logic [31:0] cnt;

   assign pressed_s = ~sync_q2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
         // Count consecutive disagreeing cycles; any agreeing cycle starts over.
         if (pressed_s != level) begin
            if (cnt >= DB_LAST) begin
               level <= pressed_s;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end else begin
            cnt <= '0;
         end
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/mode_ctrl.sv
// rtl/mode_ctrl.sv - button-driven one-hot mode selector with display mux and alarm arbitration
module mode_ctrl
   import watch_pkg::*;
#(
   parameter int          DB_CYCLES    = 250000,
   parameter logic [31:0] ALARM_CYCLES = 32'd1500000000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_BTNS-1:0]          btn_n,
   input  logic [N_MODES-1:0]         norm,
   input  logic [N_MODES*DISP_W-1:0]  disp_bus,
   input  logic [N_MODES-1:0]         alarm_req,
   output logic [N_MODES-1:0]         mode,
   output logic [N_BTNS-1:0]          btn_p,
   output logic [DISP_W-1:0]          out,
   output logic [7:0]                 o_m,
   output logic                       alarm,
   output logic [N_MODES-1:0]         alarm_ack
);

   logic [N_BTNS-1:0]  press_raw;
   alarm_state_t       state;
   alarm_state_t       state_nxt;
   logic [2:0]         src;
   logic [2:0]         src_nxt;
   logic [31:0]        cnt;
   logic [31:0]        cnt_nxt;
   logic [N_MODES-1:0] mode_nxt;
   logic [N_MODES-1:0] ack_nxt;
   logic [2:0]         mode_idx;
   logic               up_p;
   logic               dn_p;
   logic               nav_ok;

   for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk  (clk),
         .rst_n(rst_n),
         .btn_n(btn_n[i]),
         .press(press_raw[i])
      );
   end

   assign alarm    = (state == RING);
   // The press that silences the alarm must not reach the mode logic downstream.
   assign btn_p    = (state == IDLE) ? press_raw : '0;
   assign mode_idx = lowest_set(mode);

   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      cnt_nxt   = cnt;
      ack_nxt   = '0;
      mode_nxt  = mode;
      up_p      = press_raw[BTN_UP];
      dn_p      = press_raw[BTN_DOWN];
      nav_ok    = (norm & mode) != '0;

      case (state)
         IDLE: begin
            if (up_p && !dn_p && nav_ok) begin
               mode_nxt = {mode[N_MODES-2:0], mode[N_MODES-1]};
            end else if (dn_p && !up_p && nav_ok) begin
               mode_nxt = {mode[0], mode[N_MODES-1:1]};
            end
            if (alarm_req != '0) begin
               state_nxt = RING;
               src_nxt   = lowest_set(alarm_req);
               cnt_nxt   = ALARM_CYCLES;
            end
         end
         RING: begin
            cnt_nxt = (cnt != 32'd0) ? cnt - 32'd1 : 32'd0;
            if (press_raw != '0) begin
               state_nxt = IDLE;
               ack_nxt   = idx_onehot(src);
               mode_nxt  = idx_onehot(src);
            end else if (cnt <= 32'd1) begin
               state_nxt = IDLE;
               ack_nxt   = idx_onehot(src);
            end else if (!alarm_req[src]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (!is_onehot(mode)) mode_nxt = N_MODES'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         src       <= 3'd0;
         cnt       <= '0;
         mode      <= N_MODES'(1);
         alarm_ack <= '0;
         out       <= '0;
         o_m       <= 8'h01;
      end else begin
         state     <= state_nxt;
         src       <= src_nxt;
         cnt       <= cnt_nxt;
         mode      <= mode_nxt;
         alarm_ack <= ack_nxt;
         out       <= disp_bus[DISP_W*mode_idx +: DISP_W];
         o_m       <= {alarm, mode};
      end
   end

endmodule

// File: tb/tb_mode_ctrl.sv
// tb/tb_mode_ctrl.sv - directed self-checking bench for mode_ctrl
module tb_mode_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [5:0]   btn_n;
   logic [6:0]   norm;
   logic [335:0] disp_bus;
   logic [6:0]   alarm_req;
   logic [6:0]   mode;
   logic [5:0]   btn_p;
   logic [47:0]  out;
   logic [7:0]   o_m;
   logic         alarm;
   logic [6:0]   alarm_ack;

   int n_chk  = 0;
   int n_fail = 0;
   int hits;
   int stray;
   int n_ring;
   int n_ack;
   int n_bp;
   logic       found;
   logic [6:0] ack_seen;
   logic [6:0] mode_seen;

   mode_ctrl #(
      .DB_CYCLES   (4),
      .ALARM_CYCLES(32'd20)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n    (btn_n),
      .norm     (norm),
      .disp_bus (disp_bus),
      .alarm_req(alarm_req),
      .mode     (mode),
      .btn_p    (btn_p),
      .out      (out),
      .o_m      (o_m),
      .alarm    (alarm),
      .alarm_ack(alarm_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] word(input int k);
      return {16'hD15A, 16'(k), 16'(k * 7 + 3)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [5:0] mask, input int hold, input int tail,
                        output int h, output int s);
      h = 0;
      s = 0;
      btn_n = ~mask;
      for (int i = 0; i < hold + tail; i++) begin
         @(negedge clk);
         if (btn_p == mask) h++;
         else if (btn_p != 6'd0) s++;
         if (i == hold - 1) btn_n = 6'h3F;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      btn_n     = 6'h3F;
      norm      = 7'h7F;
      alarm_req = 7'h00;
      for (int k = 0; k < 7; k++) disp_bus[48*k +: 48] = word(k);
      repeat (3) @(negedge clk);
      chk("rst_mode",  64'(mode),      64'h01);
      chk("rst_btn_p", 64'(btn_p),     64'h00);
      chk("rst_out",   64'(out),       64'h00);
      chk("rst_o_m",   64'(o_m),       64'h01);
      chk("rst_alarm", 64'(alarm),     64'h0);
      chk("rst_ack",   64'(alarm_ack), 64'h00);

      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_mode", 64'(mode), 64'h01);
      chk("rel_out",  64'(out),  64'(word(0)));
      chk("rel_o_m",  64'(o_m),  64'h01);

      press(6'b000001, 8, 12, hits, stray);
      chk("up_hits",  64'(hits),  64'd1);
      chk("up_stray", 64'(stray), 64'd0);
      chk("up_mode",  64'(mode),  64'b0000010);
      chk("up_out",   64'(out),   64'(word(1)));
      chk("up_o_m",   64'(o_m),   64'h02);

      press(6'b000001, 3, 12, hits, stray);
      chk("glitch_hits", 64'(hits), 64'd0);
      chk("glitch_mode", 64'(mode), 64'b0000010);

      press(6'b000010, 8, 12, hits, stray);
      chk("down1_mode", 64'(mode), 64'b0000001);
      press(6'b000010, 8, 12, hits, stray);
      chk("down_wrap_mode", 64'(mode), 64'b1000000);
      chk("down_wrap_out",  64'(out),  64'(word(6)));
      press(6'b000001, 8, 12, hits, stray);
      chk("up_wrap_mode", 64'(mode), 64'b0000001);

      press(6'b000011, 8, 12, hits, stray);
      chk("both_hits", 64'(hits), 64'd1);
      chk("both_mode", 64'(mode), 64'b0000001);

      norm = 7'b1111110;
      press(6'b000001, 8, 12, hits, stray);
      chk("masked_hits", 64'(hits), 64'd1);
      chk("masked_mode", 64'(mode), 64'b0000001);
      norm = 7'h7F;

      // Alarm silenced by esc.
      alarm_req = 7'b0010100;
      @(negedge clk);
      chk("ring_alarm", 64'(alarm), 64'd1);
      @(negedge clk);
      chk("ring_o_m", 64'(o_m), 64'h81);
      btn_n     = 6'b011111;
      n_ack     = 0;
      n_bp      = 0;
      found     = 1'b0;
      ack_seen  = 7'd0;
      mode_seen = 7'd0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (btn_p != 6'd0) n_bp++;
         if (alarm_ack != 7'd0) begin
            n_ack++;
            if (!found) begin
               found     = 1'b1;
               ack_seen  = alarm_ack;
               mode_seen = mode;
               chk("esc_alarm_low", 64'(alarm), 64'd0);
               alarm_req = 7'd0;
               btn_n     = 6'h3F;
            end
         end
      end
      chk("esc_found",   64'(found),     64'd1);
      chk("esc_ack",     64'(ack_seen),  64'b0000100);
      chk("esc_mode",    64'(mode_seen), 64'b0000100);
      chk("esc_ack_cnt", 64'(n_ack),     64'd1);
      chk("esc_btn_p",   64'(n_bp),      64'd0);
      chk("esc_idle",    64'(alarm),     64'd0);

      // Alarm timeout followed by immediate re-entry, then drop of the request.
      alarm_req = 7'b0010000;
      n_ring    = 0;
      found     = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (alarm_ack != 7'd0) found = 1'b1;
         else if (alarm) n_ring++;
      end
      chk("to_found",  64'(found),     64'd1);
      chk("to_cycles", 64'(n_ring),    64'd20);
      chk("to_ack",    64'(alarm_ack), 64'b0010000);
      chk("to_alarm",  64'(alarm),     64'd0);
      chk("to_mode",   64'(mode),      64'b0000100);
      @(negedge clk);
      chk("rering_alarm", 64'(alarm),     64'd1);
      chk("rering_ack",   64'(alarm_ack), 64'd0);
      alarm_req = 7'd0;
      @(negedge clk);
      chk("drop_alarm", 64'(alarm),     64'd0);
      chk("drop_ack",   64'(alarm_ack), 64'd0);

      // Reset during RING.
      alarm_req = 7'b0000001;
      repeat (2) @(negedge clk);
      chk("pre_rst_alarm", 64'(alarm), 64'd1);
      rst_n     = 1'b0;
      alarm_req = 7'd0;
      @(negedge clk);
      chk("rst_ring_alarm", 64'(alarm),     64'd0);
      chk("rst_ring_ack",   64'(alarm_ack), 64'd0);
      chk("rst_ring_mode",  64'(mode),      64'b0000001);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_alarm", 64'(alarm),     64'd0);
      chk("post_rst_ack",   64'(alarm_ack), 64'd0);

      // Reset during a debounce in progress.
      btn_n = 6'b111110;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      btn_n = 6'h3F;
      n_bp  = 0;
      repeat (12) begin
         @(negedge clk);
         if (btn_p != 6'd0) n_bp++;
      end
      chk("rst_db_pulses", 64'(n_bp), 64'd0);
      chk("rst_db_mode",   64'(mode), 64'b0000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 250000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 The module SHALL have parameter ALARM_CYCLES, default 32'd1500000000, meaning the alarm auto-timeout in cycles.
REQ-003 The module SHALL have ports: clk  in  1  system clock; all logic on posedge.
REQ-004 The module SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-005 The module SHALL have ports: btn_n  in  6  raw active-low buttons, bit order {esc,enter,right,left,down,up} = [5:0].
REQ-006 The module SHALL have ports: norm  in  7  per-mode "in normal (non-edit) state" flags.
REQ-007 The module SHALL have ports: disp_bus  in  336  seven 48-bit display words; mode k occupies bits [48k+47:48k].
REQ-008 The module SHALL have ports: alarm_req  in  7  per-mode alarm request levels.
REQ-009 The module SHALL have ports: mode  out  7  one-hot active mode; btn_p  out  6  one-cycle press pulses; out  out  48  selected display word; o_m  out  8  indicator LEDs; alarm  out  1  buzzer; alarm_ack  out  7  one-cycle acknowledge to the alarm source.

Function
REQ-010 Each btn_n bit SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-011 A released-to-pressed debounced transition SHALL produce exactly one btn_p pulse, in the cycle after the debounced level changes; release produces no pulse.
REQ-012 When alarm=0, an up pulse with norm&mode nonzero SHALL rotate mode left by one (bit6 wraps to bit0) in the next cycle; a down pulse SHALL rotate right (bit0 wraps to bit6).
REQ-013 Simultaneous up and down pulses SHALL leave mode unchanged; pulses while norm&mode == 0 SHALL be ignored, not queued.
REQ-014 mode SHALL always be one-hot; an illegal value SHALL be forced to 7'b0000001 on the next cycle.
REQ-015 out SHALL be registered: the disp_bus word of the active mode, valid one cycle after mode changes.
REQ-016 o_m SHALL be {alarm, mode}, registered.
REQ-017 Alarm FSM states SHALL be IDLE and RING; IDLE->RING when any alarm_req bit is 1, latching src = lowest set index and loading the timeout counter with ALARM_CYCLES.
REQ-018 In RING, alarm=1 and the counter decrements every cycle; exit to IDLE on (a) any btn_p pulse, (b) counter reaching 0, or (c) alarm_req[src] falling to 0.
REQ-019 On exit via (a) or (b), alarm_ack[src] SHALL pulse for one cycle; on exit via (a), mode SHALL become one-hot src in the same cycle.
REQ-020 In RING, and in the cycle an exit via (a) occurs, btn_p SHALL be forced to 0 (the acknowledging press is consumed).
REQ-021 Requests from other sources during RING SHALL be ignored; if still asserted after return to IDLE, they SHALL start a new RING on the following cycle.

Reset
REQ-022 While rst_n=0 at posedge clk: mode=7'b0000001, btn_p=0, out=0, o_m=8'h01, alarm=0, alarm_ack=0, FSM=IDLE, debounced levels=released, all counters cleared.
REQ-023 Reset asserted mid-debounce or mid-RING SHALL discard the operation; no pulse or ack is emitted on reset exit.

Structure
REQ-024 A shared package watch_pkg SHALL hold N_MODES=7, DISP_W=48, the mode index constants (DATE..LADDER = 0..6), the button index constants and the alarm state enum.
REQ-025 The debouncer plus edge detector SHALL be a sub-module btn_debounce, instantiated six times.

Verification (DB_CYCLES=4, ALARM_CYCLES=20)
REQ-026 Reset release: mode=0000001, o_m=8'h01, out=disp_bus[47:0] after one cycle.
REQ-027 Hold up for 8 cycles with norm=7'h7F: exactly one btn_p[0] pulse, then mode=0000010; 3-cycle glitch: no pulse.
REQ-028 Down from mode=0000001: mode=1000000; up and down pulses in the same cycle: mode unchanged; norm=0: no change.
REQ-029 alarm_req=7'b0010100 with mode=0000001: RING with src=2, alarm=1; esc press: alarm_ack=0000100 pulse, mode=0000100, btn_p stays 0.
REQ-030 alarm_req[4] held with no press: alarm drops after 20 cycles, alarm_ack=0010000 pulse; request still high: RING re-enters next cycle.
REQ-031 rst_n low during RING: alarm=0, alarm_ack=0, mode=0000001 next cycle.
